// File: rtl/uart_receiver.sv
// UART receiver: oversampled by s_tick, LSB-first frame of one start bit, DATA_WIDTH data bits
// and one stop bit. Outputs are registered; rx_done_tick pulses for one clk per completed frame.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned TIME       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  s_tick,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rx_done_tick,
  output logic                  frame_err
);

  localparam int unsigned TickW = $clog2(TIME);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [TickW-1:0] TickMid = TickW'(TIME / 2 - 1);
  localparam logic [TickW-1:0] TickEnd = TickW'(TIME - 1);
  localparam logic [BitW-1:0]  BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                  state_q, state_d;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;
  logic                    rx_meta_q, rx_s_q;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (tick_q == TickMid) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (!rx_s_q) begin
              state_d = StData;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (tick_q == TickEnd) begin
            tick_d  = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
            if (bit_q == BitLast) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (tick_q == TickEnd) begin
            dout_d  = shreg_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter TIME, default 16, giving s_tick pulses per bit period; it must be even and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-006 The block SHALL have port s_tick, input, 1 bit: the oversampling strobe, one clk wide, TIME pulses per bit.
REQ-007 The block SHALL have port dout, output, DATA_WIDTH bits: the last received data word.
REQ-008 The block SHALL have port rx_done_tick, output, 1 bit: a one-clk pulse on frame completion.
REQ-009 The block SHALL have port frame_err, output, 1 bit: high when the last completed frame had a low stop bit.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); the FSM samples only the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, plus a tick counter of clog2(TIME) bits and a bit counter of clog2(DATA_WIDTH)+1 bits.
REQ-012 In IDLE, on any clk with rx_s==0, the FSM SHALL move to START and clear the tick counter; s_tick is not required for this transition.
REQ-013 In START, on s_tick with tick counter==TIME/2-1, the FSM SHALL sample rx_s: if 0, go to DATA and clear both counters; if 1, return to IDLE (glitch rejected) with no output change.
REQ-014 In DATA, on s_tick with tick counter==TIME-1, the FSM SHALL shift rx_s into the MSB of the shift register (LSB-first frame) and clear the tick counter.
REQ-015 At that DATA sample point, if the bit counter==DATA_WIDTH-1 the FSM SHALL go to STOP; otherwise it increments the bit counter and stays in DATA.
REQ-016 In STOP, on s_tick with tick counter==TIME-1, the FSM SHALL load dout from the shift register, set frame_err to ~rx_s, pulse rx_done_tick, and return to IDLE.
REQ-017 Apart from the sample points above, on each s_tick the FSM SHALL increment the tick counter and hold state; without s_tick all state SHALL hold; the tick counter never wraps.
REQ-018 Samples SHALL fall at mid-bit: TIME/2 ticks after the detected start edge, then every TIME ticks.
REQ-019 dout, rx_done_tick and frame_err SHALL all be registered outputs.
REQ-020 rx_done_tick SHALL be high for exactly the one clk following the edge that captured the stop sample.
REQ-021 dout and frame_err SHALL hold their values until the next frame completes.
REQ-022 On a frame error, dout SHALL still update; frame_err qualifies that word.
REQ-023 If rx_s is still 0 when the FSM re-enters IDLE after a low stop bit, a new reception SHALL start on the next clk (break-condition behaviour).
REQ-024 Back-to-back frames with no idle bit between the stop bit and the next start bit SHALL be received without loss.

Reset
REQ-025 While reset==0, the state SHALL be IDLE, both counters and the shift register 0, both synchronizer flops 1, dout 0, rx_done_tick 0, and frame_err 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no rx_done_tick pulse; the first start edge after reset release is received normally.

Verification
REQ-027 The bench SHALL cover a basic frame: DATA_WIDTH=4, TIME=16, s_tick every clk, frame 0,0,1,0,1,1 (data 4'hA) -> dout=4'hA, one rx_done_tick pulse, frame_err=0.
REQ-028 The bench SHALL cover glitch rejection: rx low for 4 s_ticks then high -> FSM back in IDLE, no rx_done_tick, dout unchanged.
REQ-029 The bench SHALL cover a framing error: data 4'h5 with stop bit 0 -> dout=4'h5, rx_done_tick pulse, frame_err=1; a following good frame 4'h6 -> frame_err=0.
REQ-030 The bench SHALL cover reset mid-DATA: reset after 2 data bits -> all outputs 0, no pulse; the next frame 4'h9 is received as 4'h9.
REQ-031 The bench SHALL cover back-to-back frames: 4'h3 then 4'hC with no idle gap -> two rx_done_tick pulses with dout 4'h3 then 4'hC.
REQ-032 The bench SHALL cover a slow tick: s_tick every 3rd clk, data 4'hF -> dout=4'hF; rx_done_tick stays one clk wide.
